// File: rtl/pwm_sample_sink.sv
// Valid/ready sample sink that turns signed samples into a 1-bit PWM DAC stream.
// Define PWM_UNDERFLOW_CNT_EN to add the saturating underflow_count output.
module pwm_sample_sink #(
    parameter int SAMPLE_WIDTH = 14,
    parameter int DAC_WIDTH    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    pwm_out,
    output logic                    sample_tick,
    output logic                    underflow
`ifdef PWM_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]             underflow_count
`endif
);

    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    logic [DAC_WIDTH-1:0] cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0] duty_q, duty_d;
    logic [DAC_WIDTH-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 pwm_q, pwm_d;
    logic                 tick_q, tick_d;
    logic                 uf_q, uf_d;

    logic                 boundary;
    logic                 xfer;
    logic [DAC_WIDTH-1:0] sample_code;

    // Valid/ready: a sample moves when sample_valid && sample_ready at posedge clk;
    // ready depends only on buffer occupancy, never on valid.
    assign sample_ready = ~buf_full_q;
    assign xfer         = sample_valid & sample_ready;
    assign boundary     = &cnt_q;

    // Offset-binary code: invert the sign bit, keep the top DAC_WIDTH bits.
    assign sample_code = {~sample[SAMPLE_WIDTH-1],
                          sample[SAMPLE_WIDTH-2 : SAMPLE_WIDTH-DAC_WIDTH]};

    generate
        if (SAMPLE_WIDTH > DAC_WIDTH) begin : g_lsb
            logic unused_lsbs;
            assign unused_lsbs = ^sample[SAMPLE_WIDTH-DAC_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        duty_d     = duty_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        pwm_d      = (cnt_q < duty_q);
        tick_d     = boundary;
        uf_d       = boundary & ~buf_full_q;
        // ready is low while the buffer is full, so load and transfer never collide
        if (boundary && buf_full_q) begin
            duty_d     = buf_q;
            buf_full_d = 1'b0;
        end else if (xfer) begin
            buf_d      = sample_code;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            duty_q     <= MIDSCALE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            uf_q       <= uf_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign underflow   = uf_q;

`ifdef PWM_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (uf_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_sample_sink.sv
// Randomized scoreboard bench for pwm_sample_sink with DAC_WIDTH=4 (16-cycle periods).
// Works with and without PWM_UNDERFLOW_CNT_EN.
module tb_pwm_sample_sink;

    localparam int SW  = 14;
    localparam int DW  = 4;
    localparam int CYC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          pwm_out;
    logic          sample_tick;
    logic          underflow;
`ifdef PWM_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_count;
`endif

    pwm_sample_sink #(.SAMPLE_WIDTH(SW), .DAC_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .sample_tick  (sample_tick),
        .underflow    (underflow)
`ifdef PWM_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];      // duties waiting in the sink buffer
    int            acc_cyc_q[$];  // cycle each buffered duty was accepted
    int            cyc = 0;       // cycles since reset release (cnt==0 at cyc 0)
    int            cur_duty = 8;
    int            hi_acc = 0;
    int            mdl_uf_cnt = 0;
    int            dut_uf_seen = 0;
    int            last_xfer_cyc = 0;
    int            xfer_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cyc %0d)", name, cyc);
    endtask

    // Offset binary by arithmetic: shift the signed range up by half, keep top DW bits.
    function automatic int to_duty(input logic [SW-1:0] s);
        int v;
        v = int'(s);
        if (v >= (1 << (SW-1))) v = v - (1 << SW);
        return (v + (1 << (SW-1))) / (1 << (SW-DW));
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit is_tick;
        bit exp_uf;
        if (rst) begin
            exp_q.delete();
            acc_cyc_q.delete();
            cyc        = 0;
            cur_duty   = 8;
            hi_acc     = 0;
            mdl_uf_cnt = 0;
        end else begin
            is_tick = (cyc > 0) && (cyc % CYC == 0);
            exp_uf  = 1'b0;
            chk("tick", int'(sample_tick), int'(is_tick));
            if (is_tick) begin
                chk("pwm_high_count", hi_acc + int'(pwm_out), cur_duty);
                // a sample accepted on the boundary cycle itself waits one more period
                if (exp_q.size() > 0 && acc_cyc_q[0] < cyc - 1) begin
                    cur_duty = int'(exp_q.pop_front());
                    void'(acc_cyc_q.pop_front());
                end else begin
                    exp_uf = 1'b1;
                    if (mdl_uf_cnt < 16'hFFFF) mdl_uf_cnt++;
                end
                hi_acc = 0;
            end else begin
                hi_acc += int'(pwm_out);
            end
            chk("underflow", int'(underflow), int'(exp_uf));
            if (underflow) dut_uf_seen++;
            if (cyc == 0) chk("reset_pwm", int'(pwm_out), 0);
            chk("ready", int'(sample_ready), int'(exp_q.size() == 0));
`ifdef PWM_UNDERFLOW_CNT_EN
            chk("underflow_count", int'(underflow_count), mdl_uf_cnt);
`endif
            if (sample_valid && sample_ready) begin
                exp_q.push_back(DW'(to_duty(sample)));
                acc_cyc_q.push_back(cyc);
                last_xfer_cyc = cyc;
                xfer_count++;
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [SW-1:0] s);
        int n;
        n = 0;
        sample       = s;
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && n < 4 * CYC) begin
            n++;
            @(negedge clk);
        end
        if (!sample_ready) fail_now("send_handshake");
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < n * CYC + 2 * CYC) begin
            @(negedge clk);
            guard++;
            if (sample_tick) seen++;
        end
        if (seen < n) fail_now("wait_ticks");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target);
        int guard;
        guard = 0;
        while ((cyc % CYC) != target && guard < 2 * CYC) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if ((cyc % CYC) != target) fail_now("wait_cnt");
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int uf0;
        int prev_cyc;
        logic [SW-1:0] base;

        #1;
        do_reset(2);
        wait_ticks(2);

        send(14'h0000);
        wait_ticks(2);

        send(14'h1FFF);
        send(14'h2000);
        wait_ticks(3);

        wait_ticks(1);
        base = SW'($urandom_range(0, 16383));
        prev_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            send(base + SW'(i * 1024));
            if (i == 0) uf0 = dut_uf_seen;
            if (i >= 2) chk("stream_spacing", last_xfer_cyc - prev_cyc, CYC);
            prev_cyc = last_xfer_cyc;
        end
        wait_ticks(1);
        chk("stream_no_underflow", dut_uf_seen - uf0, 0);

        send(SW'($urandom_range(0, 16383)));
        wait_ticks(1);
        uf0 = dut_uf_seen;
        wait_ticks(2);
        chk("underflow_pulses", dut_uf_seen - uf0, 2);

        wait_cnt(15);
        uf0 = dut_uf_seen;
        send(14'h1000);
        wait_ticks(1);
        chk("boundary_xfer_underflow", dut_uf_seen - uf0, 1);
        wait_ticks(2);
        chk("boundary_xfer_loaded", dut_uf_seen - uf0, 2);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            send(SW'($urandom()));
        end
        wait_ticks(3);

        wait_ticks(1);
        send(14'h3ABC);
        wait_cnt(7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", int'(sample_ready), 1);
        chk("reset_tick", int'(sample_tick), 0);
        wait_ticks(3);

        chk("transfers_seen", int'(xfer_count > 30), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
